sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 119 +++++++++++
 tb/tb_sipo_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from a strobed serial
// stream and hands them to a consumer through a valid/ready holding register.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             shift,
   input  logic             sin,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RECV} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;

   logic             complete;
   logic [WIDTH-1:0] word;
   logic             ovr_set;
   logic             ferr_set;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
      if (MSB_FIRST != 0) return {sr[WIDTH-2:0], b};
      else                return {b, sr[WIDTH-1:1]};
   endfunction

   // Frame assembly: a completing shift wins over start, so the finished word is kept
   // and the start simply opens the next frame.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      complete = 1'b0;
      word     = shift_in(sr_q, sin);
      ferr_set = 1'b0;

      if (state_q == RECV && shift && cnt_q == CW'(WIDTH - 1)) begin
         complete = 1'b1;
         sr_d     = '0;
         cnt_d    = '0;
         state_d  = start ? RECV : IDLE;
      end else if (start) begin
         ferr_set = (state_q == RECV) && (cnt_q != '0);
         state_d  = RECV;
         if (shift) begin
            sr_d  = shift_in('0, sin);
            cnt_d = CW'(1);
         end else begin
            sr_d  = '0;
            cnt_d = '0;
         end
      end else if (state_q == RECV && shift) begin
         sr_d  = word;
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Holding register and sticky flags; a set event in the same cycle beats clr_err.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_set = 1'b0;

      if (complete) begin
         if (!valid_q || dout_ready) begin
            dout_d  = word;
            valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end

      ovr_d  = ovr_set  | (ovr_q  & ~clr_err);
      ferr_d = ferr_set | (ferr_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overrun    = ovr_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: one MSB-first and one LSB-first instance share the same stimulus;
// per-cycle vector table plus hand-written reset sequences.
module tb_sipo_rx;

   typedef struct {
      logic       st, sh, sin, rdy, clr;
      logic       valid;
      logic [3:0] dm, dl;
      logic       ovr, ferr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, shift, sin, dout_ready, clr_err;
   logic [3:0] dout_m, dout_l;
   logic       valid_m, valid_l, ovr_m, ovr_l, ferr_m, ferr_l;

   int checks = 0;
   int fails  = 0;

   vec_t vecs[49];
   vec_t hand1[9];
   vec_t hand2[6];

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .sin(sin),
      .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
      .overrun(ovr_m), .frame_err(ferr_m), .clr_err(clr_err)
   );

   sipo_rx #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .sin(sin),
      .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
      .overrun(ovr_l), .frame_err(ferr_l), .clr_err(clr_err)
   );

   function automatic vec_t mk(input logic st, sh, s, rdy, clr, v,
                               input logic [3:0] dm, dl, input logic o, f);
      vec_t r;
      r.st = st; r.sh = sh; r.sin = s; r.rdy = rdy; r.clr = clr;
      r.valid = v; r.dm = dm; r.dl = dl; r.ovr = o; r.ferr = f;
      return r;
   endfunction

   task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic v, input logic [3:0] dm, dl,
                              input logic o, f);
      compareField({tag, " msb.dout"},      32'(dout_m),  32'(dm));
      compareField({tag, " lsb.dout"},      32'(dout_l),  32'(dl));
      compareField({tag, " msb.valid"},     32'(valid_m), 32'(v));
      compareField({tag, " lsb.valid"},     32'(valid_l), 32'(v));
      compareField({tag, " msb.overrun"},   32'(ovr_m),   32'(o));
      compareField({tag, " lsb.overrun"},   32'(ovr_l),   32'(o));
      compareField({tag, " msb.frame_err"}, 32'(ferr_m),  32'(f));
      compareField({tag, " lsb.frame_err"}, 32'(ferr_l),  32'(f));
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      start      = v.st;
      shift      = v.sh;
      sin        = v.sin;
      dout_ready = v.rdy;
      clr_err    = v.clr;
      @(posedge clk);
      #1;
      checkOutput(tag, v.valid, v.dm, v.dl, v.ovr, v.ferr);
   endtask

   initial begin
      // Basic word 1,0,1,1 -> MSB B / LSB D, then accepted, stray shift ignored
      vecs[0]  = mk(1,1,1,1,0, 0,4'h0,4'h0,0,0);
      vecs[1]  = mk(0,1,0,1,0, 0,4'h0,4'h0,0,0);
      vecs[2]  = mk(0,0,0,1,0, 0,4'h0,4'h0,0,0);
      vecs[3]  = mk(0,1,1,1,0, 0,4'h0,4'h0,0,0);
      vecs[4]  = mk(0,1,1,1,0, 1,4'hB,4'hD,0,0);
      vecs[5]  = mk(0,0,0,1,0, 0,4'hB,4'hD,0,0);
      vecs[6]  = mk(0,1,1,1,0, 0,4'hB,4'hD,0,0);
      // Word 5 held, word A dropped -> overrun, then clr_err
      vecs[7]  = mk(1,1,0,0,0, 0,4'hB,4'hD,0,0);
      vecs[8]  = mk(0,1,1,0,0, 0,4'hB,4'hD,0,0);
      vecs[9]  = mk(0,1,0,0,0, 0,4'hB,4'hD,0,0);
      vecs[10] = mk(0,1,1,0,0, 1,4'h5,4'hA,0,0);
      vecs[11] = mk(1,1,1,0,0, 1,4'h5,4'hA,0,0);
      vecs[12] = mk(0,1,0,0,0, 1,4'h5,4'hA,0,0);
      vecs[13] = mk(0,1,1,0,0, 1,4'h5,4'hA,0,0);
      vecs[14] = mk(0,1,0,0,0, 1,4'h5,4'hA,1,0);
      vecs[15] = mk(0,0,0,0,1, 1,4'h5,4'hA,0,0);
      // Word 3 completes while held word is accepted in the same cycle
      vecs[16] = mk(1,1,0,0,0, 1,4'h5,4'hA,0,0);
      vecs[17] = mk(0,1,0,0,0, 1,4'h5,4'hA,0,0);
      vecs[18] = mk(0,1,1,0,0, 1,4'h5,4'hA,0,0);
      vecs[19] = mk(0,1,1,1,0, 1,4'h3,4'hC,0,0);
      vecs[20] = mk(0,0,0,1,0, 0,4'h3,4'hC,0,0);
      // Two bits then restart with word 9 -> frame_err
      vecs[21] = mk(1,1,1,1,0, 0,4'h3,4'hC,0,0);
      vecs[22] = mk(0,1,1,1,0, 0,4'h3,4'hC,0,0);
      vecs[23] = mk(1,1,1,1,0, 0,4'h3,4'hC,0,1);
      vecs[24] = mk(0,1,0,1,0, 0,4'h3,4'hC,0,1);
      vecs[25] = mk(0,1,0,1,0, 0,4'h3,4'hC,0,1);
      vecs[26] = mk(0,1,1,1,0, 1,4'h9,4'h9,0,1);
      vecs[27] = mk(0,0,0,1,1, 0,4'h9,4'h9,0,0);
      // Start on the completing edge: word E delivered, no frame_err
      vecs[28] = mk(1,1,1,1,0, 0,4'h9,4'h9,0,0);
      vecs[29] = mk(0,1,1,1,0, 0,4'h9,4'h9,0,0);
      vecs[30] = mk(0,1,1,1,0, 0,4'h9,4'h9,0,0);
      vecs[31] = mk(1,1,0,1,0, 1,4'hE,4'h7,0,0);
      vecs[32] = mk(0,1,0,1,0, 0,4'hE,4'h7,0,0);
      // frame_err set wins over a same-cycle clr_err
      vecs[33] = mk(1,0,0,1,1, 0,4'hE,4'h7,0,1);
      vecs[34] = mk(0,0,0,1,1, 0,4'hE,4'h7,0,0);
      vecs[35] = mk(0,1,0,1,0, 0,4'hE,4'h7,0,0);
      vecs[36] = mk(0,1,0,1,0, 0,4'hE,4'h7,0,0);
      vecs[37] = mk(0,1,0,1,0, 0,4'hE,4'h7,0,0);
      vecs[38] = mk(0,1,1,1,0, 1,4'h1,4'h8,0,0);
      vecs[39] = mk(0,0,0,1,0, 0,4'h1,4'h8,0,0);
      // overrun set wins over a same-cycle clr_err
      vecs[40] = mk(1,1,1,0,0, 0,4'h1,4'h8,0,0);
      vecs[41] = mk(0,1,1,0,0, 0,4'h1,4'h8,0,0);
      vecs[42] = mk(0,1,1,0,0, 0,4'h1,4'h8,0,0);
      vecs[43] = mk(0,1,1,0,0, 1,4'hF,4'hF,0,0);
      vecs[44] = mk(1,1,0,0,0, 1,4'hF,4'hF,0,0);
      vecs[45] = mk(0,1,0,0,0, 1,4'hF,4'hF,0,0);
      vecs[46] = mk(0,1,0,0,0, 1,4'hF,4'hF,0,0);
      vecs[47] = mk(0,1,0,0,1, 1,4'hF,4'hF,1,0);
      vecs[48] = mk(0,0,0,1,1, 0,4'hF,4'hF,0,0);

      // Word 6 held, then a partial frame with frame_err before reset
      hand1[0] = mk(1,1,0,0,0, 0,4'hF,4'hF,0,0);
      hand1[1] = mk(0,1,1,0,0, 0,4'hF,4'hF,0,0);
      hand1[2] = mk(0,1,1,0,0, 0,4'hF,4'hF,0,0);
      hand1[3] = mk(0,1,0,0,0, 1,4'h6,4'h6,0,0);
      hand1[4] = mk(1,1,1,0,0, 1,4'h6,4'h6,0,0);
      hand1[5] = mk(0,1,1,0,0, 1,4'h6,4'h6,0,0);
      hand1[6] = mk(1,1,1,0,0, 1,4'h6,4'h6,0,1);
      hand1[7] = mk(0,1,1,0,0, 1,4'h6,4'h6,0,1);
      hand1[8] = mk(0,1,1,0,0, 1,4'h6,4'h6,0,1);
      // After reset: stray shift ignored, then frame C (LSB-first reads 3)
      hand2[0] = mk(0,1,1,1,0, 0,4'h0,4'h0,0,0);
      hand2[1] = mk(1,1,1,1,0, 0,4'h0,4'h0,0,0);
      hand2[2] = mk(0,1,1,1,0, 0,4'h0,4'h0,0,0);
      hand2[3] = mk(0,1,0,1,0, 0,4'h0,4'h0,0,0);
      hand2[4] = mk(0,1,0,1,0, 1,4'hC,4'h3,0,0);
      hand2[5] = mk(0,0,0,1,0, 0,4'hC,4'h3,0,0);

      rst_n = 1'b1; start = 1'b0; shift = 1'b0; sin = 1'b0;
      dout_ready = 1'b0; clr_err = 1'b0;
      #2 rst_n = 1'b0;
      #1 checkOutput("reset", 0, 4'h0, 4'h0, 0, 0);
      #4 rst_n = 1'b1;

      for (int i = 0; i < 49; i++)
         applyStimulus(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 9; i++)
         applyStimulus(hand1[i], $sformatf("pre_reset%0d", i));

      start = 1'b0; shift = 1'b0;
      #3 rst_n = 1'b0;
      #1 checkOutput("async_reset", 0, 4'h0, 4'h0, 0, 0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         applyStimulus(hand2[i], $sformatf("post_reset%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
